adder_bist_checker: RTL and testbench

- On-chip self-test engine for the WIDTH-bit full-adder blocks (ripple or lookahead).
- Sweeps every (A, B, Cin) combination into a DUT, samples {Cout, S} after a settle window, compares against a golden sum, and reports error count and pass/fail.
- Acts as the response-checking end of the adder interface; the vector generator is built in so it runs standalone on the FPGA.

---
 rtl/adder_bist_checker.sv | 171 +++++++++++++++++
 tb/tb_adder_bist_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adder_bist_checker.sv
// adder_bist_checker: self-test engine that sweeps every {A,B,Cin} vector into an adder and checks {Cout,S}.
// Latency: each vector takes 2+SETTLE_CYCLES clocks; done rises one clock after the final check.
// Backpressure: none; start is ignored while busy, rst aborts a sweep at once. Optional macro ADDER_BIST_FAIL_CAPTURE_EN.
module adder_bist_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_cin,
  input  logic [WIDTH-1:0]   dut_s,
  input  logic               dut_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH+1:0] err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output logic               fail_cin,
  output logic [WIDTH-1:0]   fail_s,
  output logic               fail_cout
);

  // Vector counter is {A, B, Cin}; error counter has one extra bit so a
  // sweep where every vector fails still fits.
  localparam int VW  = 2*WIDTH+1;
  localparam int EW  = 2*WIDTH+2;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [VW-1:0]   vec_q;
  logic [EW-1:0]   err_q;
  logic [SCW-1:0]  settle_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;

  logic [WIDTH:0]  golden;
  logic            mismatch;
  logic            last_vec;
  logic            start_acc;
  logic [EW-1:0]   err_d;

  // Operands come straight from the vector register, so the DUT sees flops.
  assign dut_a     = vec_q[VW-1 -: WIDTH];
  assign dut_b     = vec_q[WIDTH:1];
  assign dut_cin   = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

  // Golden sum, compare result, and the error count after this check.
  always_comb begin
    golden    = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
    mismatch  = ({dut_cout, dut_s} != golden);
    last_vec  = &vec_q;
    start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    err_d     = mismatch ? (err_q + EW'(1)) : err_q;
  end

  // Sweep sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      err_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_APPLY;
            vec_q    <= '0;
            err_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        S_APPLY: begin
          state_q  <= S_WAIT;
          settle_q <= '0;
        end
        S_WAIT: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= S_CHECK;
          end else begin
            settle_q <= settle_q + SCW'(1);
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          if (last_vec) begin
            // Counter parks on all-ones; it never wraps back to zero.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= S_APPLY;
            vec_q   <= vec_q + VW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
  logic             captured_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic             fail_cin_q;
  logic [WIDTH-1:0] fail_s_q;
  logic             fail_cout_q;

  // Latch only the first failing vector of a sweep; later failures are ignored.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      captured_q  <= 1'b0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_cin_q  <= 1'b0;
      fail_s_q    <= '0;
      fail_cout_q <= 1'b0;
    end else if ((state_q == S_CHECK) && mismatch && !captured_q) begin
      captured_q  <= 1'b1;
      fail_a_q    <= dut_a;
      fail_b_q    <= dut_b;
      fail_cin_q  <= dut_cin;
      fail_s_q    <= dut_s;
      fail_cout_q <= dut_cout;
    end
  end

  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_cin  = fail_cin_q;
  assign fail_s    = fail_s_q;
  assign fail_cout = fail_cout_q;
`else
  assign fail_a    = '0;
  assign fail_b    = '0;
  assign fail_cin  = 1'b0;
  assign fail_s    = '0;
  assign fail_cout = 1'b0;
`endif

endmodule

// File: tb/tb_adder_bist_checker.sv
// tb_adder_bist_checker: drives the checker against a behavioural adder with injectable faults.
// Latency: expects done 1536 clocks after an accepted start for WIDTH=4, SETTLE_CYCLES=1.
// Backpressure: none; exercises ignored start while busy and reset mid-sweep.
module tb_adder_bist_checker;
  localparam int W  = 4;
  localparam int NV = 512;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dut_a, dut_b, dut_s;
  logic         dut_cin, dut_cout;
  logic         busy, done, pass;
  logic [2*W+1:0] err_count;
  logic [W-1:0] fail_a, fail_b, fail_s;
  logic         fail_cin, fail_cout;

  int checks = 0;
  int errors = 0;

  // 0 = good adder, 1 = S[0] stuck 0, 2 = Cout stuck 0, 3 = random per-vector flips
  int           mode = 0;
  logic [W:0]   flip [NV];

  always #5 clk = ~clk;

  adder_bist_checker #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_s(dut_s), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin),
    .fail_s(fail_s), .fail_cout(fail_cout)
  );

  // Adder under test: plain integer sum, then the selected fault applied.
  function automatic int resp(input int a, input int b, input int cin);
    int r;
    r = a + b + cin;
    case (mode)
      1: r = r & 'h1e;
      2: r = r & 'h0f;
      3: r = r ^ int'(flip[a*32 + b*2 + cin]);
      default: ;
    endcase
    return r;
  endfunction

  always_comb begin
    {dut_cout, dut_s} = 5'(resp(int'(dut_a), int'(dut_b), int'(dut_cin)));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the whole operand space in sweep order.
  task automatic model(output int cnt, output int fa, output int fb, output int fc,
                       output int fs, output int fco);
    int r;
    bit first;
    cnt = 0; fa = 0; fb = 0; fc = 0; fs = 0; fco = 0; first = 1'b0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          r = resp(a, b, c);
          if (r != a + b + c) begin
            cnt++;
            if (!first) begin
              first = 1'b1;
              fa = a; fb = b; fc = c; fs = r % 16; fco = r / 16;
            end
          end
        end
  endtask

  task automatic run_sweep(input string tag, input int repulse_at);
    int cycles;
    bit busy_ok;
    int ecnt, fa, fb, fc, fs, fco;
    model(ecnt, fa, fb, fc, fs, fco);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    chk({tag, "_err_clr"}, err_count, 0);
    chk({tag, "_done_clr"}, done, 0);
    cycles = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 5000; n++) begin
      @(posedge clk); #1;
      start = (n == repulse_at);
      if (done) begin
        cycles = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_cycles"}, cycles, 1536);
    chk({tag, "_busy_held"}, busy_ok, 1);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_err"}, err_count, ecnt);
    chk({tag, "_pass"}, pass, (ecnt == 0));
`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    chk({tag, "_fail_a"}, fail_a, fa);
    chk({tag, "_fail_b"}, fail_b, fb);
    chk({tag, "_fail_cin"}, fail_cin, fc);
    chk({tag, "_fail_s"}, fail_s, fs);
    chk({tag, "_fail_cout"}, fail_cout, fco);
`else
    chk({tag, "_fail_a"}, fail_a, 0);
    chk({tag, "_fail_b"}, fail_b, 0);
    chk({tag, "_fail_cin"}, fail_cin, 0);
    chk({tag, "_fail_s"}, fail_s, 0);
    chk({tag, "_fail_cout"}, fail_cout, 0);
`endif
  endtask

  initial begin
    for (int v = 0; v < NV; v++) flip[v] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ops", {dut_a, dut_b, dut_cin}, 0);
    chk("rst_fail", {fail_a, fail_b, fail_cin, fail_s, fail_cout}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Good adder, with a stray start at cycle 500 that must be ignored.
    mode = 0;
    run_sweep("good", 500);

    // Fixed faults; each start from DONE must clear the previous result.
    mode = 1;
    run_sweep("s0", 0);
    chk("s0_err_const", err_count, 256);
    mode = 2;
    run_sweep("cout", 0);
    chk("cout_err_const", err_count, 256);

    // Reset 100 cycles into a faulty sweep.
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("mid_err_nonzero", (err_count != 0), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ops", {dut_a, dut_b, dut_cin}, 0);
    chk("abort_err", err_count, 0);
    chk("abort_fail", {fail_a, fail_b, fail_cin, fail_s, fail_cout}, 0);
    @(posedge clk); #1;
    chk("abort_idle", busy, 0);
    mode = 0;
    run_sweep("post_rst", 0);

    // rst and start together: reset wins.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_done", done, 0);

    // Random sparse faults.
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < NV; v++)
        flip[v] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      mode = 3;
      run_sweep($sformatf("rand%0d", k), (k == 1) ? 777 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
